ram_loader: RTL

Streaming write front-end for the accelerator's dual-port `RAM`. It accepts a block of words over a valid/ready handshake and writes them into consecutive RAM addresses through RAM port 1 (`we1`/`addr1`/`data1`). It also reports busy/done status to the controller, which then reads the loaded data through port 2. It sits directly upstream of `RAM`, between the host/ODE-coefficient source and memory.

---
 rtl/ode_mem_pkg.sv | 13 +
 rtl/ram_loader_addr_gen.sv | 34 +++
 rtl/ram_loader.sv | 91 +++++++++
 3 files changed

// File: rtl/ode_mem_pkg.sv
// Shared definitions for the ODE memory subsystem: loader FSM encoding and RAM geometry defaults.
// The loader and the RAM both import this package so their address/word widths cannot drift apart.
package ode_mem_pkg;
  localparam int DEF_ADDRESS_SIZE = 4;
  localparam int DEF_WORD_SIZE    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_t;
endpackage

// File: rtl/ram_loader_addr_gen.sv
// Loadable wrapping write-address counter plus remaining-words down-counter; zero latency.
// Steps once per accepted word; asserts last while exactly one word remains.
module ram_loader_addr_gen
  import ode_mem_pkg::*;
#(
  parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [ADDRESS_SIZE-1:0] base_addr,
  input  logic [ADDRESS_SIZE:0]   count,
  input  logic                    step,
  output logic [ADDRESS_SIZE-1:0] addr,
  output logic                    last
);
  logic [ADDRESS_SIZE:0] remaining;

  // Address wraps naturally at 2^ADDRESS_SIZE; remaining needs the extra bit for a full-RAM load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base_addr;
      remaining <= count;
    end else if (step) begin
      addr      <= addr + 1'b1;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == {{ADDRESS_SIZE{1'b0}}, 1'b1});
endmodule

// File: rtl/ram_loader.sv
// Streams a block of words into consecutive RAM port-1 addresses; one register stage to the RAM.
// in_ready is high only in LOAD (state-only); optional RAM_LOADER_CHECKSUM_EN adds a running word sum.
module ram_loader
  import ode_mem_pkg::*;
#(
  parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int WORD_SIZE    = DEF_WORD_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDRESS_SIZE-1:0] base_addr,
  input  logic [ADDRESS_SIZE:0]   count,
  input  logic [WORD_SIZE-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    ram_we,
  output logic [ADDRESS_SIZE-1:0] ram_addr,
  inout  wire  [WORD_SIZE-1:0]    ram_data
`ifdef RAM_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_SIZE-1:0]    checksum
`endif
);
  ld_state_t               state;
  logic [WORD_SIZE-1:0]    wr_data;
  logic [ADDRESS_SIZE-1:0] cur_addr;
  logic                    last;
  logic                    start_idle;
  logic                    start_load;
  logic                    accept;

  assign start_idle = (state == ST_IDLE) && start;
  assign start_load = start_idle && (count != '0);
  assign in_ready   = (state == ST_LOAD);
  assign accept     = in_valid && in_ready;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

  ram_loader_addr_gen #(
    .ADDRESS_SIZE(ADDRESS_SIZE)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (start_load),
    .base_addr(base_addr),
    .count    (count),
    .step     (accept),
    .addr     (cur_addr),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      wr_data  <= '0;
    end else begin
      // Write stage: each accepted word is presented to the RAM for exactly one cycle.
      ram_we <= accept;
      if (accept) begin
        ram_addr <= cur_addr;
        wr_data  <= in_data;
      end
      case (state)
        ST_IDLE:  if (start) state <= (count == '0) ? ST_DONE : ST_LOAD;
        ST_LOAD:  if (accept && last) state <= ST_FLUSH;
        ST_FLUSH: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign ram_data = ram_we ? wr_data : {WORD_SIZE{1'bz}};

`ifdef RAM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      checksum <= '0;
    end else if (start_idle) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + in_data;
    end
  end
`endif
endmodule
